// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 core and the arbiter that feeds it.
// State encoding and block/digest sizes live here so both sides agree.
package sha256_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2,
        S_DRAIN  = 2'd3
    } arb_state_e;

    localparam int BLOCK_WORDS  = 16;
    localparam int DIGEST_WORDS = 8;
    localparam int WCNT_W       = 5;

endpackage

// File: rtl/sha256_core_arbiter_if.sv
// Requester-facing bus of the SHA-256 arbiter: two word streams in, one
// tagged digest stream out. Requesters use master, the arbiter uses slave.
interface sha256_core_arbiter_if #(
    parameter int DATA_WIDTH = 32
);

    logic [1:0]              req_valid;
    logic [2*DATA_WIDTH-1:0] req_data;
    logic [1:0]              req_ready;

    logic                    rsp_valid;
    logic                    rsp_id;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic                    rsp_last;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_data,
        input  rsp_last
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output rsp_valid,
        output rsp_id,
        output rsp_data,
        output rsp_last
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// the requester named by prio. Purely combinational.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = (req == 2'b11) ? prio : req[1];
    end

endmodule

// File: rtl/sha256_core_arbiter.sv
// Shares one SHA-256 core between two block requesters: grants one, streams
// its 16 words into the core, then routes the 8-word digest back tagged.
module sha256_core_arbiter
    import sha256_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sha256_core_arbiter_if.slave  bus,
    output logic                  core_dv_out,
    output logic [DATA_WIDTH-1:0] core_msg_out,
    input  logic [DATA_WIDTH-1:0] core_hash_in,
    input  logic                  core_dv_in,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DCNT_W = $clog2(DIGEST_WORDS);

    localparam logic [WCNT_W-1:0] WCNT_LAST  = WCNT_W'(BLOCK_WORDS - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(DIGEST_WORDS - 1);
    localparam logic [TCNT_W-1:0] TCNT_LIMIT = TCNT_W'(TIMEOUT_CYCLES);

    arb_state_e          state_q, state_d;
    logic                prio_q, prio_d;
    logic                gnt_id_q, gnt_id_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [TCNT_W-1:0]   tcnt_inc;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic                timeout_err_q, timeout_err_d;

    logic                arb_valid;
    logic                arb_id;
    logic                granted_valid;
    logic [DATA_WIDTH-1:0] granted_data;

    rr_arb2 u_arb (
        .req       (bus.req_valid),
        .prio      (prio_q),
        .gnt_valid (arb_valid),
        .gnt_id    (arb_id)
    );

    assign granted_valid = bus.req_valid[gnt_id_q];
    assign granted_data  = gnt_id_q ? bus.req_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                    : bus.req_data[DATA_WIDTH-1:0];
    assign tcnt_inc      = tcnt_q + TCNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            prio_q        <= 1'b0;
            gnt_id_q      <= 1'b0;
            wcnt_q        <= '0;
            tcnt_q        <= '0;
            dcnt_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            prio_q        <= prio_d;
            gnt_id_q      <= gnt_id_d;
            wcnt_q        <= wcnt_d;
            tcnt_q        <= tcnt_d;
            dcnt_q        <= dcnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Grant is held from arbitration until the digest drains or the watchdog fires.
    always_comb begin
        state_d       = state_q;
        prio_d        = prio_q;
        gnt_id_d      = gnt_id_q;
        wcnt_d        = wcnt_q;
        tcnt_d        = tcnt_q;
        dcnt_d        = dcnt_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    gnt_id_d = arb_id;
                    state_d  = S_STREAM;
                end
            end
            S_STREAM: begin
                if (granted_valid) begin
                    if (wcnt_q == WCNT_LAST) begin
                        wcnt_d  = '0;
                        state_d = S_WAIT;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (core_dv_in) begin
                    tcnt_d  = '0;
                    dcnt_d  = DCNT_W'(1);
                    state_d = S_DRAIN;
                end else if (tcnt_inc == TCNT_LIMIT) begin
                    tcnt_d        = '0;
                    timeout_err_d = 1'b1;
                    prio_d        = ~gnt_id_q;
                    state_d       = S_IDLE;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            S_DRAIN: begin
                if (!core_dv_in) begin
                    dcnt_d        = '0;
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else if (dcnt_q == DCNT_LAST) begin
                    dcnt_d  = '0;
                    prio_d  = ~gnt_id_q;
                    state_d = S_IDLE;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Word and digest paths are zero-latency pass-throughs gated by state.
    always_comb begin
        bus.req_ready = '0;
        core_dv_out   = 1'b0;
        core_msg_out  = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_id    = 1'b0;
        bus.rsp_data  = '0;
        bus.rsp_last  = 1'b0;

        case (state_q)
            S_STREAM: begin
                bus.req_ready[gnt_id_q] = 1'b1;
                core_dv_out             = granted_valid;
                core_msg_out            = granted_data;
            end
            S_WAIT, S_DRAIN: begin
                bus.rsp_valid = core_dv_in;
                bus.rsp_id    = gnt_id_q;
                bus.rsp_data  = core_hash_in;
                bus.rsp_last  = (state_q == S_DRAIN) && core_dv_in && (dcnt_q == DCNT_LAST);
            end
            default: ;
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Bench for sha256_core_arbiter: a behavioural core stand-in answers each
// block with a digest, and a scoreboard checks every tagged response word.
module tb_sha256_core_arbiter;

    typedef logic [31:0] blk_t [16];

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        rv [2];
    logic [31:0] rd [2];
    logic        core_dv_out;
    logic [31:0] core_msg_out;
    logic [31:0] core_hash;
    logic        core_dv_in;
    logic        busy;
    logic        timeout_err;

    int   checks;
    int   failures;
    int   cyc;
    int   dv_pulses;
    int   rsp_count;
    int   last_rsp_cyc [2];
    exp_t sb_q [$];
    logic core_mute;

    sha256_core_arbiter_if #(.DATA_WIDTH(32)) bus ();

    assign bus.req_valid = {rv[1], rv[0]};
    assign bus.req_data  = {rd[1], rd[0]};

    sha256_core_arbiter #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .core_dv_out  (core_dv_out),
        .core_msg_out (core_msg_out),
        .core_hash_in (core_hash),
        .core_dv_in   (core_dv_in),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic blk_t make_abc();
        blk_t b;
        foreach (b[i]) b[i] = 32'h0;
        b[0]  = 32'h61626380;
        b[15] = 32'h00000018;
        return b;
    endfunction

    function automatic blk_t make_toy();
        blk_t b;
        foreach (b[i]) b[i] = 32'h10000000 + 32'(i * 32'h01010101);
        return b;
    endfunction

    function automatic logic [31:0] abc_digest(input int j);
        case (j)
            0:       return 32'hBA7816BF;
            1:       return 32'h8F01CFEA;
            2:       return 32'h414140DE;
            3:       return 32'h5DAE2223;
            4:       return 32'hB00361A3;
            5:       return 32'h96177A9C;
            6:       return 32'hB410FF61;
            default: return 32'hF20015AD;
        endcase
    endfunction

    function automatic logic [31:0] toy_word(input blk_t b, input int j);
        logic [31:0] acc;
        acc = 32'h9E3779B9 ^ 32'(j);
        for (int i = 0; i < 16; i++) acc = {acc[26:0], acc[31:27]} + (b[i] ^ 32'(i + 16 * j));
        return acc;
    endfunction

    function automatic logic [31:0] digest_word(input blk_t b, input int j);
        blk_t a;
        a = make_abc();
        if (b == a) return abc_digest(j);
        return toy_word(b, j);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic pushExpected(input logic id, input blk_t b);
        exp_t e;
        for (int j = 0; j < 8; j++) begin
            e.id   = id;
            e.data = digest_word(b, j);
            e.last = (j == 7);
            sb_q.push_back(e);
        end
    endtask

    // Core stand-in: loads on MP_dv_in, answers 3 cycles after the 16th word
    // with 8 consecutive digest words; core_mute models a core that never answers.
    initial begin
        blk_t        cblk;
        logic [31:0] cdig [8];
        int          ccnt;
        int          clat;
        int          cemit;
        ccnt       = 0;
        clat       = 0;
        cemit      = 0;
        core_dv_in = 1'b0;
        core_hash  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ccnt = 0; clat = 0; cemit = 0;
                core_dv_in = 1'b0;
                core_hash  = 32'h0;
            end else if (cemit > 0) begin
                core_dv_in = 1'b1;
                core_hash  = cdig[8 - cemit];
                cemit--;
            end else begin
                core_dv_in = 1'b0;
                core_hash  = 32'hA5A5A5A5;
                if (clat > 0) begin
                    clat--;
                    if (clat == 0) cemit = 8;
                end
            end
            @(negedge clk);
            if (!rst_n) begin
                ccnt = 0; clat = 0; cemit = 0;
            end else if (core_dv_out) begin
                cblk[ccnt] = core_msg_out;
                ccnt++;
                if (ccnt == 16) begin
                    ccnt = 0;
                    if (!core_mute) begin
                        for (int j = 0; j < 8; j++) cdig[j] = digest_word(cblk, j);
                        clat = 3;
                    end
                end
            end
        end
    end

    // Response monitor: every rsp_valid word is popped and compared.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && core_dv_out) dv_pulses++;
        if (rst_n && bus.rsp_valid) begin
            rsp_count++;
            if (bus.rsp_last) last_rsp_cyc[bus.rsp_id] = cyc;
            if (sb_q.size() == 0) begin
                checkOutput("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                checkOutput("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                checkOutput("rsp_last", 64'(bus.rsp_last), 64'(e.last));
            end
        end
    end

    task automatic applyStimulus(input int id, input blk_t b, input int gap_at, input int gap_len,
                                 input int stop_at, output int start_c, output int first_c,
                                 output int last_c);
        int   sent;
        int   budget;
        int   both_rdy;
        logic acc;
        sent     = 0;
        budget   = 0;
        both_rdy = 0;
        first_c  = -1;
        last_c   = -1;
        @(posedge clk);
        #1;
        start_c = cyc;
        rd[id]  = b[0];
        rv[id]  = 1'b1;
        while (sent < 16 && sent != stop_at && budget < 400) begin
            @(negedge clk);
            acc = bus.req_ready[id] && rv[id];
            if (bus.req_ready == 2'b11) both_rdy++;
            if (acc) begin
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
            end
            @(posedge clk);
            #1;
            budget++;
            if (acc) begin
                sent++;
                if (sent == gap_at) begin
                    rv[id] = 1'b0;
                    rd[id] = 32'h0;
                    repeat (gap_len) begin
                        @(posedge clk);
                        #1;
                    end
                    rv[id] = 1'b1;
                end
                if (sent < 16) rd[id] = b[sent];
            end
        end
        rv[id] = 1'b0;
        rd[id] = 32'h0;
        checkOutput($sformatf("both_ready_r%0d", id), 64'(both_rdy), 64'd0);
        if (budget >= 400) checkOutput($sformatf("stream_stalled_r%0d", id), 64'(sent), 64'd16);
    endtask

    task automatic waitIdle(input string tag, input int max_cycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || sb_q.size() != 0) && n < max_cycles);
        checkOutput(tag, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_terr"}, 64'(timeout_err), 64'd0);
        checkOutput({tag, "_ready"}, 64'(bus.req_ready), 64'd0);
        checkOutput({tag, "_dv"}, 64'(core_dv_out), 64'd0);
        checkOutput({tag, "_msg"}, 64'(core_msg_out), 64'd0);
        checkOutput({tag, "_rspv"}, 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        blk_t abc_blk;
        blk_t toy_blk;
        int   st0, fa0, la0, st1, fa1, la1;
        int   n, p0, r0;
        abc_blk   = make_abc();
        toy_blk   = make_toy();
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        dv_pulses = 0;
        rsp_count = 0;
        last_rsp_cyc[0] = 0;
        last_rsp_cyc[1] = 0;
        core_mute = 1'b0;
        rst_n     = 1'b0;
        rv[0] = 1'b0; rv[1] = 1'b0;
        rd[0] = 32'h0; rd[1] = 32'h0;

        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;

        $display("[TB] single requester 0, abc block");
        pushExpected(1'b0, abc_blk);
        applyStimulus(0, abc_blk, -1, 0, -1, st0, fa0, la0);
        checkOutput("first_accept_latency", 64'(fa0 - st0), 64'd1);
        checkOutput("last_accept_latency", 64'(la0 - st0), 64'd16);
        waitIdle("drain_single_r0", 200);

        $display("[TB] requester 1 with 3 idle cycles after word 5");
        pushExpected(1'b1, abc_blk);
        p0 = dv_pulses;
        applyStimulus(1, abc_blk, 6, 3, -1, st1, fa1, la1);
        waitIdle("drain_gap_r1", 200);
        checkOutput("gap_dv_pulses", 64'(dv_pulses - p0), 64'd16);
        checkOutput("gap_last_accept", 64'(la1 - st1), 64'd19);

        $display("[TB] tie with prio 0");
        pushExpected(1'b0, abc_blk);
        pushExpected(1'b1, toy_blk);
        fork
            applyStimulus(0, abc_blk, -1, 0, -1, st0, fa0, la0);
            applyStimulus(1, toy_blk, -1, 0, -1, st1, fa1, la1);
        join
        waitIdle("drain_tie", 300);
        checkOutput("tie_r0_first", 64'(fa0 - st0), 64'd1);
        checkOutput("tie_r1_rearb", 64'(fa1 - last_rsp_cyc[0]), 64'd2);

        $display("[TB] silent core, watchdog abort");
        core_mute = 1'b1;
        r0 = rsp_count;
        applyStimulus(0, toy_blk, -1, 0, -1, st0, fa0, la0);
        n = 0;
        do begin
            @(negedge clk);
            if (busy) n++;
        end while (busy && n < 100);
        core_mute = 1'b0;
        checkOutput("wait_cycles", 64'(n), 64'd20);
        checkOutput("timeout_err_set", 64'(timeout_err), 64'd1);
        checkOutput("abort_no_rsp", 64'(rsp_count - r0), 64'd0);

        $display("[TB] tie after abort, prio toggled to requester 1");
        pushExpected(1'b1, abc_blk);
        pushExpected(1'b0, toy_blk);
        fork
            applyStimulus(0, toy_blk, -1, 0, -1, st0, fa0, la0);
            applyStimulus(1, abc_blk, -1, 0, -1, st1, fa1, la1);
        join
        waitIdle("drain_tie_after_abort", 300);
        checkOutput("prio_toggled_r1_first", 64'(fa1 - st1), 64'd1);
        checkOutput("timeout_err_sticky", 64'(timeout_err), 64'd1);

        $display("[TB] reset at word 10, then fresh abc block");
        applyStimulus(0, abc_blk, -1, 0, 10, st0, fa0, la0);
        rst_n = 1'b0;
        #1;
        checkResetState("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pushExpected(1'b0, abc_blk);
        applyStimulus(0, abc_blk, -1, 0, -1, st0, fa0, la0);
        waitIdle("drain_after_reset", 200);
        checkOutput("post_reset_latency", 64'(fa0 - st0), 64'd1);

        repeat (5) @(negedge clk);
        checkOutput("sb_empty_final", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
